// File: rtl/pwm_capture.sv
// pwm_capture: demodulates a 1-bit PWM audio stream into DATA_WIDTH-bit samples.
// The duty cycle is measured over frames of 2^DATA_WIDTH clocks. Frames are aligned
// to a rising edge of the input. Samples are packed little-endian into
// FIFO_DATA_WIDTH-bit words for a sample FIFO.
//
// Ports:
//   clkdived      capture clock
//   rstn          asynchronous active-low reset
//   cap_en        capture enable (level); dropping it discards the partial frame and word
//   pwm_in        asynchronous PWM audio input
//   fifo_full     FIFO cannot accept a write this cycle
//   fifo_wr_en    one-cycle write strobe
//   fifo_wr_data  packed sample word, held between writes
//   sample        last completed sample
//   sample_valid  one-cycle strobe, sample updated
//   overflow      sticky: a word was dropped on a full FIFO (cleared in idle)
//
// Optional feature: define PWM_CAPTURE_SIGNED_EN to invert each sample's MSB
// after saturation. This gives two's complement around mid-scale.
module pwm_capture #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                       clkdived,
  input  logic                       rstn,
  input  logic                       cap_en,
  input  logic                       pwm_in,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  output logic [DATA_WIDTH-1:0]      sample,
  output logic                       sample_valid,
  output logic                       overflow
);

  localparam int unsigned SPW = FIFO_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned IdxW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SPW - 1);

  typedef enum logic [1:0] {StIdle, StAlign, StCapture} state_e;

  state_e                     state_q, state_d;
  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       pwm_d_q;
  logic [DATA_WIDTH-1:0]      frame_q, frame_d;
  logic [DATA_WIDTH:0]        hi_q, hi_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [FIFO_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [FIFO_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]      sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       wr_en_q, wr_en_d;
  logic                       ovf_q, ovf_d;

  logic                       pwm_s;
  logic                       rise;
  logic [DATA_WIDTH:0]        hi_final;
  logic [DATA_WIDTH-1:0]      samp_val;
  logic [FIFO_DATA_WIDTH-1:0] word;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d_q;

  // Count includes the current cycle so the frame-end cycle is part of the sample.
  assign hi_final = hi_q + (DATA_WIDTH + 1)'(pwm_s);

  always_comb begin
    samp_val = hi_final[DATA_WIDTH] ? '1 : hi_final[DATA_WIDTH-1:0];
`ifdef PWM_CAPTURE_SIGNED_EN
    samp_val[DATA_WIDTH-1] = ~samp_val[DATA_WIDTH-1];
`endif
    word = pack_q;
    word[idx_q*DATA_WIDTH +: DATA_WIDTH] = samp_val;
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    hi_d      = hi_q;
    idx_d     = idx_q;
    pack_d    = pack_q;
    wr_data_d = wr_data_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    wr_en_d   = 1'b0;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        frame_d = '0;
        hi_d    = '0;
        idx_d   = '0;
        pack_d  = '0;
        ovf_d   = 1'b0;
        if (cap_en) state_d = StAlign;
      end
      StAlign: begin
        if (!cap_en) begin
          state_d = StIdle;
        end else if (rise) begin
          // The edge cycle is frame cycle 0 and is high.
          state_d = StCapture;
          frame_d = DATA_WIDTH'(1);
          hi_d    = (DATA_WIDTH + 1)'(1);
        end
      end
      StCapture: begin
        if (!cap_en) begin
          state_d = StIdle;
          frame_d = '0;
          hi_d    = '0;
        end else begin
          frame_d = frame_q + DATA_WIDTH'(1);
          hi_d    = hi_final;
          if (&frame_q) begin
            hi_d     = '0;
            sample_d = samp_val;
            valid_d  = 1'b1;
            if (idx_q == LastIdx) begin
              // The word is either written or dropped; packing restarts either way.
              idx_d     = '0;
              pack_d    = '0;
              wr_data_d = word;
              if (fifo_full) ovf_d = 1'b1;
              else           wr_en_d = 1'b1;
            end else begin
              idx_d  = idx_q + IdxW'(1);
              pack_d = word;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkdived or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      pwm_d_q   <= 1'b0;
      frame_q   <= '0;
      hi_q      <= '0;
      idx_q     <= '0;
      pack_q    <= '0;
      wr_data_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q   <= pwm_s;
      frame_q   <= frame_d;
      hi_q      <= hi_d;
      idx_q     <= idx_d;
      pack_q    <= pack_d;
      wr_data_q <= wr_data_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

endmodule
